pipelined_subtractor_32bit: RTL and testbench

- 32-bit unsigned subtractor with borrow-in, pipelined as 4 byte-slice stages. Companion to the pipelined 32-bit adder; it covers the inverse operation for the datapath.
- Adds a valid/ready handshake with a global-stall pipeline, so it can sit between buffered producer and consumer stages.
- Computes diff = num_a - num_b - Bin and the borrow-out Bout.

---
 rtl/sub_pkg.sv | 17 +
 rtl/sub_slice.sv | 24 ++
 rtl/pipelined_subtractor_32bit.sv | 140 ++++++++++++++
 tb/tb_pipelined_subtractor_32bit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared parameters and stage record for the byte-sliced pipelined subtractor.
package sub_pkg;
    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int STAGES = WIDTH / SLICE;

    typedef logic [SLICE-1:0] slice_t;

    // Resolved bytes accumulate in d; operand bytes not yet consumed ride in a/b.
    typedef struct packed {
        logic                valid;
        logic                borrow;
        slice_t [STAGES-1:0] a;
        slice_t [STAGES-1:0] b;
        slice_t [STAGES-1:0] d;
    } stage_t;
endpackage

// File: rtl/sub_slice.sv
// Combinational SLICE-bit ripple-borrow subtractor: {bout,d} = a - b - bin.
module sub_slice
    import sub_pkg::*;
(
    input  slice_t a,
    input  slice_t b,
    input  logic   bin,
    output slice_t d,
    output logic   bout
);
    logic [SLICE:0] bw;

    always_comb begin
        bw    = '0;
        d     = '0;
        bw[0] = bin;
        for (int i = 0; i < SLICE; i++) begin
            d[i]    = a[i] ^ b[i] ^ bw[i];
            bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
        end
    end

    assign bout = bw[SLICE];
endmodule

// File: rtl/pipelined_subtractor_32bit.sv
// 32-bit subtractor, one byte resolved per stage, valid/ready with a global stall.
// Define SUB_SIGNED_FLAGS_EN to add registered two's-complement ovf/neg outputs.
module pipelined_subtractor_32bit
    import sub_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num_a,
    input  logic [WIDTH-1:0] num_b,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             Bout,
    output logic             zero
`ifdef SUB_SIGNED_FLAGS_EN
    ,
    output logic             ovf,
    output logic             neg
`endif
);
    stage_t            src   [STAGES];
    stage_t            stg_d [STAGES-1];
    stage_t            stg_q [STAGES-1];
    slice_t            sd    [STAGES];
    logic [STAGES-1:0] sbo;
    logic              adv;
    logic              vld_q;
    logic [WIDTH-1:0]  diff_d;
    logic [WIDTH-1:0]  diff_q;
    logic              bout_q;
    logic              zero_d;
    logic              zero_q;
    logic              unused_bits;

    assign adv      = !vld_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        src[0]        = '0;
        src[0].valid  = in_valid;
        src[0].borrow = Bin;
        src[0].a      = num_a;
        src[0].b      = num_b;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = stg_q[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slice
        sub_slice u_slice (
            .a    (src[g].a[g]),
            .b    (src[g].b[g]),
            .bin  (src[g].borrow),
            .d    (sd[g]),
            .bout (sbo[g])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES-1; k++) begin
            stg_d[k]        = src[k];
            stg_d[k].d[k]   = sd[k];
            stg_d[k].borrow = sbo[k];
        end
    end

    // Stages 0..STAGES-2: bubbles only clear the valid bit so data never picks up X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES-1; k++) begin
                stg_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES-1; k++) begin
                if (src[k].valid) begin
                    stg_q[k] <= stg_d[k];
                end else begin
                    stg_q[k].valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        diff_d                   = stg_q[STAGES-2].d;
        diff_d[WIDTH-1 -: SLICE] = sd[STAGES-1];
        zero_d                   = (diff_d == '0);
    end

`ifdef SUB_SIGNED_FLAGS_EN
    logic ovf_d;
    logic ovf_q;
    logic neg_q;

    // Operand sign bits are still in the skew chain at the last stage.
    assign ovf_d = (src[STAGES-1].a[STAGES-1][SLICE-1] != src[STAGES-1].b[STAGES-1][SLICE-1])
                && (diff_d[WIDTH-1] != src[STAGES-1].a[STAGES-1][SLICE-1]);
`endif

    // Output stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q  <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
`ifdef SUB_SIGNED_FLAGS_EN
            ovf_q  <= 1'b0;
            neg_q  <= 1'b0;
`endif
        end else if (adv) begin
            vld_q <= src[STAGES-1].valid;
            if (src[STAGES-1].valid) begin
                diff_q <= diff_d;
                bout_q <= sbo[STAGES-1];
                zero_q <= zero_d;
`ifdef SUB_SIGNED_FLAGS_EN
                ovf_q  <= ovf_d;
                neg_q  <= diff_d[WIDTH-1];
`endif
            end
        end
    end

    assign out_valid = vld_q;
    assign diff      = diff_q;
    assign Bout      = bout_q;
    assign zero      = zero_q;
`ifdef SUB_SIGNED_FLAGS_EN
    assign ovf       = ovf_q;
    assign neg       = neg_q;
`endif

    // Already-consumed operand bytes and the not-yet-resolved top byte of the last register.
    assign unused_bits = ^{stg_q[STAGES-2].a[STAGES-2:0], stg_q[STAGES-2].b[STAGES-2:0],
                           stg_q[STAGES-2].d[STAGES-1]};
endmodule

// File: tb/tb_pipelined_subtractor_32bit.sv
// Self-checking bench for pipelined_subtractor_32bit: directed vectors plus a queue-based model.
module tb_pipelined_subtractor_32bit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        Bin = 1'b0;
    logic [31:0] num_a = '0;
    logic [31:0] num_b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        Bout;
    logic        zero;
    logic [31:0] diff;
`ifdef SUB_SIGNED_FLAGS_EN
    logic        ovf;
    logic        neg;
    logic [1:0]  fq[$];
    logic [1:0]  fe;
`endif

    typedef struct packed {
        logic        bo;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          nchk = 0;
    int          nfail = 0;
    int          n_ret = 0;
    int          r0;
    int          wn;
    logic [31:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          done;

    always #5 clk = ~clk;

    pipelined_subtractor_32bit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num_a     (num_a),
        .num_b     (num_b),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .Bout      (Bout),
        .zero      (zero)
`ifdef SUB_SIGNED_FLAGS_EN
        ,
        .ovf       (ovf),
        .neg       (neg)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bi);
        logic [32:0] r;
        exp_t        m;
        r    = {1'b0, a} - {1'b0, b} - {32'd0, bi};
        m.d  = r[31:0];
        m.bo = r[32];
        return m;
    endfunction

    // Scoreboard: outputs are sampled on the falling edge, between active edges.
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
`ifdef SUB_SIGNED_FLAGS_EN
            fq.delete();
`endif
        end else begin
            check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL stale_out: out_valid=1 with no outstanding beat, diff=%h", diff);
                end else begin
                    e = q[0];
                    check("diff", 64'(diff), 64'(e.d));
                    check("Bout", 64'(Bout), 64'(e.bo));
                    check("zero", 64'(zero), 64'(e.d == 32'd0));
`ifdef SUB_SIGNED_FLAGS_EN
                    fe = fq[0];
                    check("ovf", 64'(ovf), 64'(fe[1]));
                    check("neg", 64'(neg), 64'(fe[0]));
                    if (out_ready) void'(fq.pop_front());
`endif
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_ret++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(num_a, num_b, Bin));
`ifdef SUB_SIGNED_FLAGS_EN
                ra = model(num_a, num_b, Bin).d;
                fq.push_back({(num_a[31] != num_b[31]) && (ra[31] != num_a[31]), ra[31]});
`endif
            end
        end
    end

    // Presents one beat and returns 1ns after the edge that accepted it.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic bi);
        bit acc = 1'b0;
        int n = 0;
        num_a    = a;
        num_b    = b;
        Bin      = bi;
        in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            nchk++;
            nfail++;
            $display("FAIL push_timeout: beat %h - %h not accepted within 200 cycles", a, b);
        end
    endtask

    task automatic send_one(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic bi, input logic [31:0] ed, input logic eb, input logic ez);
        push(a, b, bi);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_early"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_diff"}, 64'(diff), 64'(ed));
        check({name, "_bout"}, 64'(Bout), 64'(eb));
        check({name, "_zero"}, 64'(zero), 64'(ez));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_bout", 64'(Bout), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        send_one("basic", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        send_one("borrow_b", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send_one("borrow_bin", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send_one("equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        send_one("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send_one("byte_ripple", 32'h0100_0000, 32'h0000_0001, 1'b0, 32'h00FF_FFFF, 1'b0, 1'b0);
        send_one("min_max", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0);
`ifdef SUB_SIGNED_FLAGS_EN
        check("min_max_ovf", 64'(ovf), 64'd1);
        check("min_max_neg", 64'(neg), 64'd0);
        send_one("neg_res", 32'h0000_0001, 32'h0000_0003, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        check("neg_res_ovf", 64'(ovf), 64'd0);
        check("neg_res_neg", 64'(neg), 64'd1);
`endif
        drain();

        // Backpressure: six back-to-back beats, consumer stalls three cycles on first result.
        r0 = n_ret;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(32'h1000_0000 + 32'(i) * 32'h0101_0101, 32'h0000_00FF * 32'(i + 1), 1'(i));
                end
            end
            begin
                wn = 0;
                while (!out_valid && wn < 20) begin
                    @(posedge clk);
                    #1;
                    wn++;
                end
                check("bp_first_valid", 64'(out_valid), 64'd1);
                held      = diff;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_valid_hold", 64'(out_valid), 64'd1);
                    check("bp_diff_hold", 64'(diff), 64'(held));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(n_ret - r0), 64'd6);

        // Reset with beats in flight: four accepted, first one already at the output.
        push(32'hAAAA_0001, 32'h0000_0001, 1'b0);
        push(32'h5555_0002, 32'h0000_0001, 1'b1);
        push(32'h0000_0010, 32'h0000_0020, 1'b0);
        push(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        check("mid_pre_valid", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_valid", 64'(out_valid), 64'd0);
        check("mid_diff", 64'(diff), 64'd0);
        check("mid_bout", 64'(Bout), 64'd0);
        check("mid_zero", 64'(zero), 64'd0);
        check("mid_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(out_valid), 64'd0);
        send_one("post_rst", 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 32'hFFFE_0000, 1'b0, 1'b0);
        drain();

        // Random traffic with input gaps and consumer stalls.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    ra = $urandom;
                    rb = (i % 8 == 0) ? ra : $urandom;
                    if (i % 13 == 0) ra = 32'd0;
                    push(ra, rb, 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
